xor_implies_sweep_ctrl: RTL

- Exhaustive-sweep controller for the 16-input xor-implies benchmark formula.
- Output is the odd parity of i_0..i_15, gated by the implication chain i_11→i_12→i_13→i_14→i_15.
- On start, steps every input vector in [lo, hi] through the formula at one vector per cycle and counts satisfying vectors.
- Captures the first and last satisfying vectors and streams each witness out on a valid/ready interface; used as the golden-count generator when checking synthesized candidate functions.

---
 rtl/xor_implies_pkg.sv | 22 ++
 rtl/xor_implies_sweep_ctrl_eval.sv | 22 ++
 rtl/xor_implies_sweep_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/xor_implies_pkg.sv
// Shared constants, FSM state type and the reference satisfying-count for the
// 16-input xor-implies sweep controller.
package xor_implies_pkg;

  localparam int N_IN     = 16;
  localparam int CHAIN_LO = 11;
  localparam int CNT_W    = 17;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Satisfying vectors over the full range: the chain bits admit N_IN-CHAIN_LO+1
  // monotone patterns, and odd parity keeps half of the 2^CHAIN_LO free patterns.
  function automatic int unsigned golden_sat_count();
    return (32'd1 << (CHAIN_LO - 1)) * 32'(N_IN - CHAIN_LO + 1);
  endfunction

endpackage

// File: rtl/xor_implies_sweep_ctrl_eval.sv
// Pure combinational xor-implies formula: odd parity of the vector, gated by
// the implication chain vec[CHAIN_LO] -> ... -> vec[N_IN-1].
module xor_implies_eval #(
  parameter int N_IN     = 16,
  parameter int CHAIN_LO = 11
) (
  input  logic [N_IN-1:0] vec,
  output logic            sat
);

  logic chain_ok_s;

  // Fold the implication chain and combine with parity.
  always_comb begin
    chain_ok_s = 1'b1;
    for (int k = CHAIN_LO; k < N_IN - 1; k++) begin
      chain_ok_s = chain_ok_s & (~vec[k] | vec[k+1]);
    end
    sat = (^vec) & chain_ok_s;
  end

endmodule

// File: rtl/xor_implies_sweep_ctrl.sv
// Exhaustive sweep controller: walks [lo, hi] one vector per cycle, counts
// satisfying vectors and streams each witness out over valid/ready.
module xor_implies_sweep_ctrl
  import xor_implies_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N_IN-1:0]  lo,
  input  logic [N_IN-1:0]  hi,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted,
  output logic [CNT_W-1:0] sat_count,
  output logic [N_IN-1:0]  first_w,
  output logic [N_IN-1:0]  last_w,
  output logic             found,
  output logic             w_valid,
  output logic [N_IN-1:0]  w_data,
  input  logic             w_ready
);

  state_e           state_q;
  logic [N_IN-1:0]  cur_q;
  logic [N_IN-1:0]  hi_q;
  logic             stg_vld_q;
  logic             w_valid_q;
  logic [N_IN-1:0]  w_data_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             aborted_q;
  logic             found_q;
  logic [CNT_W-1:0] sat_count_q;
  logic [N_IN-1:0]  first_w_q;
  logic [N_IN-1:0]  last_w_q;

  logic             cur_sat_s;
  logic             stall_s;
  logic             retire_s;
  logic             w_hit_s;

  xor_implies_eval #(
    .N_IN    (N_IN),
    .CHAIN_LO(CHAIN_LO)
  ) u_eval (
    .vec(cur_q),
    .sat(cur_sat_s)
  );

  // Stage handshake decode: a non-satisfying entry retires without waiting.
  always_comb begin
    stall_s  = w_valid_q & ~w_ready;
    retire_s = stg_vld_q & (~w_valid_q | w_ready);
    w_hit_s  = w_valid_q & w_ready;
  end

  // Controller FSM, vector counter, one-entry stage and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_q       <= N_IN'(0);
      hi_q        <= N_IN'(0);
      stg_vld_q   <= 1'b0;
      w_valid_q   <= 1'b0;
      w_data_q    <= N_IN'(0);
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      aborted_q   <= 1'b0;
      found_q     <= 1'b0;
      sat_count_q <= CNT_W'(0);
      first_w_q   <= N_IN'(0);
      last_w_q    <= N_IN'(0);
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sat_count_q <= CNT_W'(0);
            found_q     <= 1'b0;
            first_w_q   <= N_IN'(0);
            last_w_q    <= N_IN'(0);
            aborted_q   <= 1'b0;
            if (lo > hi) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_q   <= 1'b0;
              cur_q   <= lo;
              hi_q    <= hi;
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN, S_DRAIN: begin
          if (abort) begin
            // The in-flight entry is dropped without being counted.
            stg_vld_q <= 1'b0;
            w_valid_q <= 1'b0;
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            if (w_hit_s) begin
              sat_count_q <= sat_count_q + CNT_W'(1);
              last_w_q    <= w_data_q;
              found_q     <= 1'b1;
              if (!found_q) begin
                first_w_q <= w_data_q;
              end
            end
            if (state_q == S_RUN) begin
              if (!stall_s) begin
                stg_vld_q <= 1'b1;
                w_valid_q <= cur_sat_s;
                w_data_q  <= cur_q;
                // Stop on hi rather than wrapping, so hi = all-ones terminates.
                if (cur_q == hi_q) begin
                  state_q <= S_DRAIN;
                end else begin
                  cur_q <= cur_q + N_IN'(1);
                end
              end
            end else if (!stg_vld_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (retire_s) begin
              stg_vld_q <= 1'b0;
              w_valid_q <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign aborted   = aborted_q;
  assign found     = found_q;
  assign sat_count = sat_count_q;
  assign first_w   = first_w_q;
  assign last_w    = last_w_q;
  assign w_valid   = w_valid_q;
  assign w_data    = w_data_q;

endmodule
